// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL lock / core reset sequencer: FSM state encoding and width.
package pll_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_STABLE    = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RUN       = 3'd3,
        ST_PLL_RST   = 3'd4
    } seq_state_e;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a single asynchronous level; chain clears to 0 on reset.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_seq.sv
// Turns raw PLL lock into a clean core reset, pixel clock-enable and PLL reset request.
// Optional LOCK_LOSS_COUNT_EN adds lock_loss_cnt, a saturating count of RUN->WAIT_LOCK drops.
module pll_lock_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int LOCK_STABLE_CYC = 1024,
    parameter int HOLD_CYC        = 256,
    parameter int WATCHDOG_CYC    = 65536,
    parameter int PLL_RST_CYC     = 16,
    parameter int CE_DIV          = 2
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               pll_locked,
    input  logic               user_reset,
    output logic               pll_rst,
    output logic               core_reset,
    output logic               ce_pix,
    output logic               ready,
    output logic [STATE_W-1:0] state
`ifdef LOCK_LOSS_COUNT_EN
    ,
    output logic [7:0]         lock_loss_cnt
`endif
);

    localparam int CNT_MAX = max_of(max_of(max_of(LOCK_STABLE_CYC, HOLD_CYC),
                                           max_of(WATCHDOG_CYC, PLL_RST_CYC)), CE_DIV);
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] WDOG_LAST   = CNT_W'(WATCHDOG_CYC - 1);
    localparam logic [CNT_W-1:0] PRST_LAST   = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] DIV_LAST    = CNT_W'(CE_DIV - 1);

    seq_state_e       r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [CNT_W-1:0] r_wdog, w_wdog_nx, w_wdog_inc;
    logic [CNT_W-1:0] r_div, w_div_nx;
    logic             r_pll_rst, r_core_reset, r_ce_pix, r_ready;
    logic             w_locked_s;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .i_clk   (clk_sys),
        .i_reset (reset),
        .i_d     (pll_locked),
        .o_q     (w_locked_s)
    );

    // Lock loss outranks user_reset, which outranks every counter expiry.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_wdog_nx  = r_wdog;
        w_div_nx   = r_div;
        w_wdog_inc = (r_wdog == WDOG_LAST) ? r_wdog : r_wdog + CNT_W'(1);
        case (r_state)
            ST_WAIT_LOCK: begin
                w_wdog_nx = w_wdog_inc;
                if (w_locked_s) begin
                    w_state_nx = ST_STABLE;
                    w_cnt_nx   = '0;
                end else if (r_wdog == WDOG_LAST) begin
                    w_state_nx = ST_PLL_RST;
                    w_cnt_nx   = '0;
                end
            end
            ST_STABLE: begin
                w_wdog_nx = w_wdog_inc;
                if (!w_locked_s) begin
                    w_state_nx = ST_WAIT_LOCK;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_nx = ST_HOLD;
                    w_cnt_nx   = '0;
                    w_wdog_nx  = '0;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!w_locked_s) begin
                    w_state_nx = ST_WAIT_LOCK;
                end else if (user_reset) begin
                    w_cnt_nx = '0;
                end else if (r_cnt == HOLD_LAST) begin
                    w_state_nx = ST_RUN;
                    w_div_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!w_locked_s) begin
                    w_state_nx = ST_WAIT_LOCK;
                end else if (user_reset) begin
                    w_state_nx = ST_HOLD;
                    w_cnt_nx   = '0;
                end else begin
                    w_div_nx = (r_div == DIV_LAST) ? '0 : r_div + CNT_W'(1);
                end
            end
            ST_PLL_RST: begin
                if (r_cnt == PRST_LAST) begin
                    w_state_nx = ST_WAIT_LOCK;
                    w_wdog_nx  = '0;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nx = ST_WAIT_LOCK;
            end
        endcase
    end

    // Outputs are decoded from the next state so they move on the same edge as the FSM.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state      <= ST_WAIT_LOCK;
            r_cnt        <= '0;
            r_wdog       <= '0;
            r_div        <= '0;
            r_pll_rst    <= 1'b0;
            r_core_reset <= 1'b1;
            r_ce_pix     <= 1'b0;
            r_ready      <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_wdog       <= w_wdog_nx;
            r_div        <= w_div_nx;
            r_pll_rst    <= (w_state_nx == ST_PLL_RST);
            r_core_reset <= (w_state_nx != ST_RUN);
            r_ce_pix     <= (w_state_nx == ST_RUN) && (w_div_nx == DIV_LAST);
            r_ready      <= (w_state_nx == ST_RUN);
        end
    end

`ifdef LOCK_LOSS_COUNT_EN
    logic [7:0] r_lock_loss;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_lock_loss <= '0;
        end else if ((r_state == ST_RUN) && !w_locked_s && (r_lock_loss != 8'hFF)) begin
            r_lock_loss <= r_lock_loss + 8'd1;
        end
    end

    assign lock_loss_cnt = r_lock_loss;
`endif

    assign pll_rst    = r_pll_rst;
    assign core_reset = r_core_reset;
    assign ce_pix     = r_ce_pix;
    assign ready      = r_ready;
    assign state      = r_state;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Directed and randomized checks of pll_lock_reset_seq against edge-count arithmetic
// and a queue-based reference model; LOCK_LOSS_COUNT_EN also checks lock_loss_cnt.
module tb_pll_lock_reset_seq;

    localparam int SYNC_STAGES     = 2;
    localparam int LOCK_STABLE_CYC = 8;
    localparam int HOLD_CYC        = 4;
    localparam int WATCHDOG_CYC    = 32;
    localparam int PLL_RST_CYC     = 3;
    localparam int CE_DIV          = 2;
    localparam int LATENCY         = SYNC_STAGES + LOCK_STABLE_CYC + HOLD_CYC + 1;

    logic       clk_sys    = 1'b0;
    logic       reset      = 1'b1;
    logic       pll_locked = 1'b0;
    logic       user_reset = 1'b0;
    logic       pll_rst, core_reset, ce_pix, ready;
    logic [2:0] state;
`ifdef LOCK_LOSS_COUNT_EN
    logic [7:0] lock_loss_cnt;
`endif
    logic [6:0] obs;
    int         n_checks = 0;
    int         n_pass   = 0;

    assign obs = {state, pll_rst, core_reset, ce_pix, ready};

    always #5 clk_sys = ~clk_sys;

    pll_lock_reset_seq #(
        .SYNC_STAGES     (SYNC_STAGES),
        .LOCK_STABLE_CYC (LOCK_STABLE_CYC),
        .HOLD_CYC        (HOLD_CYC),
        .WATCHDOG_CYC    (WATCHDOG_CYC),
        .PLL_RST_CYC     (PLL_RST_CYC),
        .CE_DIV          (CE_DIV)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .pll_locked (pll_locked),
        .user_reset (user_reset),
        .pll_rst    (pll_rst),
        .core_reset (core_reset),
        .ce_pix     (ce_pix),
        .ready      (ready),
        .state      (state)
`ifdef LOCK_LOSS_COUNT_EN
        ,
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    // Reference model: the FSM sees pll_locked as sampled SYNC_STAGES edges earlier.
    int m_phase = 0;
    int m_count = 0;
    int m_wdog  = 0;
    int m_div   = 0;
    int m_loss  = 0;
    bit m_seen;
    bit m_hist[$];

    always @(posedge clk_sys) begin
        if (reset) begin
            m_phase = 0;
            m_count = 0;
            m_wdog  = 0;
            m_div   = 0;
            m_loss  = 0;
            m_hist  = {};
            repeat (SYNC_STAGES) m_hist.push_back(1'b0);
        end else begin
            m_seen = m_hist.pop_front();
            m_hist.push_back(pll_locked);
            case (m_phase)
                0: begin
                    if (m_seen) begin
                        m_phase = 1;
                        m_count = 0;
                    end else if (m_wdog == WATCHDOG_CYC - 1) begin
                        m_phase = 4;
                        m_count = 0;
                    end
                    if (m_wdog < WATCHDOG_CYC - 1) m_wdog++;
                end
                1: begin
                    if (m_wdog < WATCHDOG_CYC - 1) m_wdog++;
                    if (!m_seen) m_phase = 0;
                    else if (m_count == LOCK_STABLE_CYC - 1) begin
                        m_phase = 2;
                        m_count = 0;
                        m_wdog  = 0;
                    end else m_count++;
                end
                2: begin
                    if (!m_seen) m_phase = 0;
                    else if (user_reset) m_count = 0;
                    else if (m_count == HOLD_CYC - 1) begin
                        m_phase = 3;
                        m_div   = 0;
                    end else m_count++;
                end
                3: begin
                    if (!m_seen) begin
                        m_phase = 0;
                        if (m_loss < 255) m_loss++;
                    end else if (user_reset) begin
                        m_phase = 2;
                        m_count = 0;
                    end else m_div = (m_div + 1) % CE_DIV;
                end
                default: begin
                    if (m_count == PLL_RST_CYC - 1) begin
                        m_phase = 0;
                        m_wdog  = 0;
                    end else m_count++;
                end
            endcase
        end
    end

    function automatic logic [6:0] pack(input int st, input bit pr, input bit cr,
                                        input bit ce, input bit rd);
        return {3'(st), pr, cr, ce, rd};
    endfunction

    function automatic logic [6:0] model_vec();
        return pack(m_phase, m_phase == 4, m_phase != 3,
                    (m_phase == 3) && (m_div == CE_DIV - 1), m_phase == 3);
    endfunction

    // State k edges after pll_locked is first sampled high (and held).
    function automatic int lock_state(input int k);
        if (k <= SYNC_STAGES) return 0;
        if (k <= SYNC_STAGES + LOCK_STABLE_CYC) return 1;
        if (k <= SYNC_STAGES + LOCK_STABLE_CYC + HOLD_CYC) return 2;
        return 3;
    endfunction

    task automatic do_reset();
        @(negedge clk_sys);
        reset      = 1'b1;
        pll_locked = 1'b0;
        user_reset = 1'b0;
        @(negedge clk_sys);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk_sys);
        @(negedge clk_sys);
        n_checks++;
        if (obs !== pack(0, 1'b0, 1'b1, 1'b0, 1'b0))
            $display("FAIL reset_values got=%b want=%b", obs, pack(0, 1'b0, 1'b1, 1'b0, 1'b0));
        else n_pass++;
`ifdef LOCK_LOSS_COUNT_EN
        n_checks++;
        if (lock_loss_cnt !== 8'd0) $display("FAIL reset_loss_cnt got=%0d want=0", lock_loss_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_lock_latency();
        int st;
        bit run, ce;
        do_reset();
        pll_locked = 1'b1;
        for (int e = 1; e <= LATENCY + 6; e++) begin
            @(negedge clk_sys);
            st  = lock_state(e);
            run = (e >= LATENCY);
            ce  = run && ((e - LATENCY) % CE_DIV == CE_DIV - 1);
            n_checks++;
            if (obs !== pack(st, 1'b0, !run, ce, run))
                $display("FAIL lock_latency edge=%0d got=%b want=%b", e, obs, pack(st, 1'b0, !run, ce, run));
            else n_pass++;
        end
    endtask

    task automatic test_watchdog();
        bit pr;
        do_reset();
        for (int e = 1; e <= 2 * (WATCHDOG_CYC + PLL_RST_CYC); e++) begin
            @(negedge clk_sys);
            pr = (e % (WATCHDOG_CYC + PLL_RST_CYC)) >= WATCHDOG_CYC;
            n_checks++;
            if (obs !== pack(pr ? 4 : 0, pr, 1'b1, 1'b0, 1'b0))
                $display("FAIL watchdog edge=%0d got=%b want=%b", e, obs, pack(pr ? 4 : 0, pr, 1'b1, 1'b0, 1'b0));
            else n_pass++;
        end
    endtask

    // One-cycle lock drop that the FSM sees while the stable count is 5.
    task automatic test_stable_glitch();
        int seen_e, drop_e, shift, st;
        seen_e = SYNC_STAGES + 1 + 5 + 1;
        drop_e = seen_e - SYNC_STAGES - 1;
        shift  = seen_e + 1 - (SYNC_STAGES + 1);
        do_reset();
        pll_locked = 1'b1;
        for (int e = 1; e <= shift + LATENCY + 2; e++) begin
            @(negedge clk_sys);
            st = (e < seen_e) ? lock_state(e) : (e == seen_e) ? 0 : lock_state(e - shift);
            n_checks++;
            if ({state, core_reset} !== {3'(st), st != 3})
                $display("FAIL stable_glitch edge=%0d got=%0d/%b want=%0d/%b", e, state, core_reset, st, st != 3);
            else n_pass++;
            if (e == drop_e) pll_locked = 1'b0;
            if (e == drop_e + 1) pll_locked = 1'b1;
        end
    endtask

    task automatic test_user_reset();
        bit run, ce;
        repeat ($urandom_range(0, 5)) @(negedge clk_sys);
        user_reset = 1'b1;
        for (int i = 0; i < HOLD_CYC + 3; i++) begin
            @(negedge clk_sys);
            user_reset = 1'b0;
            run = (i >= HOLD_CYC);
            ce  = run && ((i - HOLD_CYC) % CE_DIV == CE_DIV - 1);
            n_checks++;
            if (obs !== pack(run ? 3 : 2, 1'b0, !run, ce, run))
                $display("FAIL user_reset i=%0d got=%b want=%b", i, obs, pack(run ? 3 : 2, 1'b0, !run, ce, run));
            else n_pass++;
        end
    endtask

    task automatic test_lock_loss_with_user_reset();
        do_reset();
        pll_locked = 1'b1;
        repeat (LATENCY + $urandom_range(0, 4)) @(negedge clk_sys);
        pll_locked = 1'b0;
        repeat (SYNC_STAGES) @(negedge clk_sys);
        n_checks++;
        if ({state, core_reset} !== {3'd3, 1'b0})
            $display("FAIL loss_before got=%0d/%b want=3/0", state, core_reset);
        else n_pass++;
        user_reset = 1'b1;
        @(negedge clk_sys);
        user_reset = 1'b0;
        n_checks++;
        if (obs !== pack(0, 1'b0, 1'b1, 1'b0, 1'b0))
            $display("FAIL loss_priority got=%b want=%b", obs, pack(0, 1'b0, 1'b1, 1'b0, 1'b0));
        else n_pass++;
`ifdef LOCK_LOSS_COUNT_EN
        n_checks++;
        if (lock_loss_cnt !== 8'd1) $display("FAIL loss_count got=%0d want=1", lock_loss_cnt);
        else n_pass++;
`endif
    endtask

    // Continues from WAIT_LOCK with a clear sync chain, so the loss count is still 1 here.
    task automatic test_reset_mid_hold();
        pll_locked = 1'b1;
        repeat (SYNC_STAGES + LOCK_STABLE_CYC + 1 + $urandom_range(0, HOLD_CYC - 2)) @(negedge clk_sys);
        n_checks++;
        if ({state, core_reset} !== {3'd2, 1'b1})
            $display("FAIL hold_reached got=%0d/%b want=2/1", state, core_reset);
        else n_pass++;
        reset = 1'b1;
        @(negedge clk_sys);
        n_checks++;
        if (obs !== pack(0, 1'b0, 1'b1, 1'b0, 1'b0))
            $display("FAIL reset_mid_hold got=%b want=%b", obs, pack(0, 1'b0, 1'b1, 1'b0, 1'b0));
        else n_pass++;
`ifdef LOCK_LOSS_COUNT_EN
        n_checks++;
        if (lock_loss_cnt !== 8'd0) $display("FAIL reset_clears_loss got=%0d want=0", lock_loss_cnt);
        else n_pass++;
`endif
        reset = 1'b0;
    endtask

    task automatic test_random();
        int run_left;
        run_left = 0;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if (run_left == 0) begin
                pll_locked = ~pll_locked;
                if (pll_locked) run_left = $urandom_range(4, 40);
                else if ($urandom_range(0, 3) == 0) run_left = $urandom_range(30, 45);
                else run_left = $urandom_range(1, 6);
            end
            run_left--;
            user_reset = ($urandom_range(0, 24) == 0);
            @(negedge clk_sys);
            n_checks++;
            if (obs !== model_vec())
                $display("FAIL random cycle=%0d got=%b want=%b", c, obs, model_vec());
            else n_pass++;
`ifdef LOCK_LOSS_COUNT_EN
            n_checks++;
            if (lock_loss_cnt !== 8'(m_loss))
                $display("FAIL random_loss cycle=%0d got=%0d want=%0d", c, lock_loss_cnt, m_loss);
            else n_pass++;
`endif
        end
        user_reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock_latency();
        test_watchdog();
        test_stable_glitch();
        test_user_reset();
        test_lock_loss_with_user_reset();
        test_reset_mid_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
